// File: rtl/lc3b_pipe_stage.sv
// Elastic pipeline register for the LC-3b pipeline: a DEPTH-entry FIFO with
// valid/ready handshake, synchronous flush and a saturating stall counter.
module lc3b_pipe_stage #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic [CNT_W-1:0] stall_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Handshake depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count < CW'(DEPTH)) & ~reset;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Modulo-DEPTH increment so non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      stall_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (in_valid && !in_ready && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= in_data;
          wr_ptr      <= ptr_inc(wr_ptr);
        end
        if (pop) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/lc3b_pipe_stage.md
Name: lc3b_pipe_stage

Overview:
- Parametrised elastic pipeline register. It replaces the fixed, always-loading IF/ID, ID/EX, EX/MEM and MEM/WB latches of the LC-3b pipeline.
- Adds valid/ready backpressure, an internal buffer of DEPTH entries, synchronous flush for branch squash, and a saturating stall-cycle counter.
- One instance sits between each pair of stages. Upstream stages stall on in_ready=0; downstream stages see bubbles as out_valid=0.

Parameters:
WIDTH, 16, payload bits per entry (npc/ir/cs/drid concatenated by the instantiating stage)
DEPTH, 2, buffer entries; legal range 2..8 (2 = skid buffer)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous active-high reset
flush  in  1  squash all buffered entries (branch taken / trap)
in_valid  in  1  upstream stage presents payload
in_ready  out  1  stage can accept payload this cycle
in_data  in  WIDTH  upstream payload
out_valid  out  1  head entry valid
out_ready  in  1  downstream stage consumes head this cycle
out_data  out  WIDTH  head entry payload
count  out  $clog2(DEPTH+1)  occupied entries
stall_cnt  out  CNT_W  cycles with in_valid=1 and in_ready=0, saturating

Behaviour:
- Reset (reset=1 at posedge):
  - count=0, read/write pointers=0, out_valid=0, stall_cnt=0.
  - in_ready is forced 0 during any cycle with reset=1.
  - out_data is don't-care while out_valid=0 and is reset to 0.
- in_ready = (count < DEPTH) & ~reset. It is a function of registered count only: no combinational path from out_ready or in_valid.
- out_valid = (count != 0). out_data = storage[rd_ptr], driven from registers.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- At each posedge (reset=0, flush=0):
  - push & ~pop: write at wr_ptr, wr_ptr++, count++.
  - pop & ~push: rd_ptr++, count--.
  - push & pop: write and read both advance; count unchanged.
  - neither: hold all state.
- Pointers wrap modulo DEPTH. Non-power-of-two DEPTH must wrap correctly, e.g. DEPTH=3 gives 0,1,2,0.
- Full (count=DEPTH): in_ready=0. A simultaneous pop does not enable a same-cycle push (no bypass). in_ready rises the cycle after the pop.
- Empty (count=0): out_valid=0. There is no flow-through, so minimum latency in_data to out_data is 1 cycle.
- Full throughput: with out_ready held 1, one entry per cycle passes through at steady state.
- Flush (flush=1, reset=0):
  - Next state: count=0, pointers=0, out_valid=0.
  - A push presented in the same cycle is discarded. A pop in the same cycle is a don't-care for downstream.
  - Flush has priority over push/pop; reset has priority over flush.
  - in_ready during a flush cycle still follows count (upstream may assert, data is dropped).
- stall_cnt:
  - Increments on every posedge where in_valid=1 and in_ready=0 and reset=0, including flush cycles.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset, not by flush.
- Reset mid-operation: all buffered entries are lost and no output is produced. Recovery is as from power-on.
- Payload is never modified. Storage has no reset requirement except that out_data reads 0 after reset.

Test Plan:
- Reset then idle, DEPTH=2: reset=1 two cycles -> count=0, out_valid=0, in_ready=0 during reset, in_ready=1 the cycle after release, stall_cnt=0.
- Streaming: in_valid=1, data 0x1000..0x1009 over 10 cycles, out_ready=1 -> out_data yields 0x1000..0x1009 in order, each 1 cycle after push, count stays <=1, stall_cnt=0.
- Backpressure/full: out_ready=0, push 0xA1, 0xA2, 0xA3 -> count=2, in_ready=0 after 2 pushes, 0xA3 held upstream. stall_cnt increments 1 per held cycle (3 held cycles -> 3). Raise out_ready -> outputs 0xA1, 0xA2, 0xA3 in order, no loss.
- Full with simultaneous pop: count=2, out_ready=1, in_valid=1 -> that cycle count drops to 1 with no push; 0xA3 is accepted the next cycle.
- Flush: count=2 (0xB1, 0xB2), flush=1 with in_valid=1 in_data=0xB3 -> next cycle count=0, out_valid=0. 0xB3 never appears at out_data; stall_cnt unchanged by flush.
- Wrap and saturation: DEPTH=3, CNT_W=4, 20 mixed push/pop cycles -> FIFO order preserved across pointer wrap. Hold in_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15.
